// File: rtl/sub_serial_seq_pkg.sv
// sub_serial_seq_pkg: shared state encoding, slice width and counter sizing
package sub_serial_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n slices; at least one bit even when n == 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_serial_seq_sub4.sv
// sub_serial_seq_sub4: 1-bit full subtractor and the 4-bit ripple subtract slice built from it
//   full_sub: a, b, bi -> d = a - b - bi (bit), bo = borrow out
//   sub4:     a[3:0], b[3:0], ci (borrow in) -> d[3:0], co (borrow out)
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module sub4
    import sub_serial_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] d,
    output logic                co
);
    logic [NIBBLE_W:0] c;

    assign c[0] = ci;
    assign co   = c[NIBBLE_W];

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        full_sub u_fs (
            .a  (a[i]),
            .b  (b[i]),
            .bi (c[i]),
            .d  (d[i]),
            .bo (c[i+1])
        );
    end
endmodule

// File: rtl/sub_serial_seq.sv
// sub_serial_seq: W-bit a - b - bin computed one nibble per clock through a single sub4 slice
//   clk, rst_n (async, active-low)
//   start, a[W-1:0], b[W-1:0], bin : request and operands, captured when not busy
//   busy : RUN in progress; done : one-cycle result-valid pulse
//   diff[W-1:0], bout, ovf : registered result, held until the next completion
module sub_serial_seq
    import sub_serial_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                     bin,
    output logic                     busy,
    output logic                     done,
    output logic [NIBBLE_W*NIBBLES-1:0] diff,
    output logic                     bout,
    output logic                     ovf
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = cnt_w(NIBBLES);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic              brw_q, brw_d, am_q, am_d, bm_q, bm_d, bout_q, bout_d, ovf_q, ovf_d;
    logic [NIBBLE_W-1:0] sub_d;
    logic              sub_co;
    logic [W+NIBBLE_W-1:0] res_cat;

    sub4 u_sub4 (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .ci (brw_q),
        .d  (sub_d),
        .co (sub_co)
    );

    // New nibble enters at the top; after NIBBLES shifts the result is aligned.
    assign res_cat = {sub_d, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        am_d    = am_q;
        bm_d    = bm_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    brw_d   = bin;
                    am_d    = a[W-1];
                    bm_d    = b[W-1];
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d = res_cat[W+NIBBLE_W-1:NIBBLE_W];
                a_d   = a_q >> NIBBLE_W;
                b_d   = b_q >> NIBBLE_W;
                brw_d = sub_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    state_d = DONE;
                    diff_d  = res_cat[W+NIBBLE_W-1:NIBBLE_W];
                    bout_d  = sub_co;
                    // Overflow only possible when operand signs differ.
                    ovf_d   = (am_q != bm_q) && (res_cat[W+NIBBLE_W-1] != am_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub_serial_seq.sv
// tb_sub_serial_seq: directed self-checking bench for sub_serial_seq (NIBBLES=4, W=16)
module tb_sub_serial_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, ovf;
    logic [15:0] diff;

    int vectors = 0;
    int miscompares = 0;

    sub_serial_seq #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Drive one start pulse and wait (bounded) for done; returns latency in
    // cycles counted from the start edge and the number of busy cycles seen.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         output int lat, output int bc);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
        lat = 1; bc = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({busy, done, diff, bout, ovf} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int lat, bc;
        do_op(16'h1234, 16'h0234, 1'b0, lat, bc);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d, want 5", lat);
        end
        vectors++;
        if (bc !== 4) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d, want 4", bc);
        end
        vectors++;
        if ({diff, bout, ovf} !== {16'h1000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_result: got diff=%h bout=%b ovf=%b, want 1000 0 0", diff, bout, ovf);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || diff !== 16'h1000) begin
            miscompares++;
            $display("FAIL basic_pulse_hold: got done=%b diff=%h, want 0 1000", done, diff);
        end
    endtask

    task automatic test_wrap;
        int lat, bc;
        do_op(16'h0000, 16'h0001, 1'b0, lat, bc);
        vectors++;
        if ({diff, bout, ovf} !== {16'hFFFF, 1'b1, 1'b0} || lat !== 5) begin
            miscompares++;
            $display("FAIL wrap_0m1: got diff=%h bout=%b ovf=%b lat=%0d, want ffff 1 0 5", diff, bout, ovf, lat);
        end
        do_op(16'h0000, 16'h0000, 1'b1, lat, bc);
        vectors++;
        if ({diff, bout, ovf} !== {16'hFFFF, 1'b1, 1'b0} || lat !== 5) begin
            miscompares++;
            $display("FAIL wrap_bin: got diff=%h bout=%b ovf=%b lat=%0d, want ffff 1 0 5", diff, bout, ovf, lat);
        end
    endtask

    task automatic test_overflow;
        int lat, bc;
        do_op(16'h8000, 16'h0001, 1'b0, lat, bc);
        vectors++;
        if ({diff, bout, ovf} !== {16'h7FFF, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_neg: got diff=%h bout=%b ovf=%b, want 7fff 0 1", diff, bout, ovf);
        end
        do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, bc);
        vectors++;
        if ({diff, bout, ovf} !== {16'h8000, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_pos: got diff=%h bout=%b ovf=%b, want 8000 1 1", diff, bout, ovf);
        end
    endtask

    task automatic test_start_while_busy;
        int first_done = -1;
        int ndone = 0;
        @(negedge clk);
        a = 16'h00F0; b = 16'h000F; bin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = i;
            end
            if (i == 1) start = 1'b0;
            if (i == 2) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0000;
            end
            if (i == 3) start = 1'b0;
        end
        vectors++;
        if (ndone !== 1 || first_done !== 5) begin
            miscompares++;
            $display("FAIL busy_ignore_done: got %0d pulses first at %0d, want 1 at 5", ndone, first_done);
        end
        vectors++;
        if (diff !== 16'h00E1) begin
            miscompares++;
            $display("FAIL busy_ignore_diff: got %h, want 00e1", diff);
        end
    endtask

    task automatic test_back_to_back;
        int d1 = -1;
        int d2 = -1;
        logic busy6 = 1'b0;
        logic [15:0] diff9 = '0;
        logic [15:0] diff5 = '0;
        @(negedge clk);
        a = 16'h00F0; b = 16'h000F; bin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            if (i == 5) diff5 = diff;
            if (i == 6) busy6 = busy;
            if (i == 9) diff9 = diff;
            if (i == 1) begin
                a = 16'h0010; b = 16'h0001;
            end
            if (i == 6) start = 1'b0;
        end
        vectors++;
        if (d1 !== 5 || d2 !== 10) begin
            miscompares++;
            $display("FAIL b2b_done_times: got %0d and %0d, want 5 and 10", d1, d2);
        end
        vectors++;
        if (busy6 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_no_idle: got busy=%b after done, want 1", busy6);
        end
        vectors++;
        if (diff5 !== 16'h00E1 || diff9 !== 16'h00E1) begin
            miscompares++;
            $display("FAIL b2b_hold: got %h/%h, want 00e1/00e1", diff5, diff9);
        end
        vectors++;
        if (diff !== 16'h000F) begin
            miscompares++;
            $display("FAIL b2b_second: got %h, want 000f", diff);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc;
        int ndone = 0;
        do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, bc);
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, diff, bout, ovf} !== 19'd0) begin
            miscompares++;
            $display("FAIL midrun_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL midrun_no_done: got %0d active cycles, want 0", ndone);
        end
        do_op(16'h0100, 16'h0001, 1'b0, lat, bc);
        vectors++;
        if ({diff, bout, ovf} !== {16'h00FF, 1'b0, 1'b0} || lat !== 5) begin
            miscompares++;
            $display("FAIL midrun_fresh: got diff=%h bout=%b ovf=%b lat=%0d, want 00ff 0 0 5", diff, bout, ovf, lat);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_overflow;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sub_serial_seq.md
Name: sub_serial_seq

Overview:
- Multi-nibble sequential subtractor. Computes diff = a - b - bin over a W-bit operand, 4 bits per clock.
- Feeds one existing sub4 ripple-subtract stage one nibble per cycle and consumes its borrow-out and difference nibble.
- A borrow register chains the nibbles across cycles.
- Provides a start/busy/done handshake so wide subtractions reuse a single 4-bit datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- a  input  W  minuend, captured on accepted start.
- b  input  W  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  W  difference result, held until the next completion.
- bout  output  1  final borrow-out (1 = unsigned a < b + bin).
- ovf  output  1  signed overflow of a - b - bin.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low (rst_n), and returns the block to IDLE.
  - Reset values: busy=0, done=0, diff=0, bout=0, ovf=0, all internal registers 0.
- States are IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge latches a, b and bin into operand shift registers and the borrow register.
  - Clears the nibble counter and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - busy=1.
  - Each cycle the sub4 stage gets the low nibbles of the operand shift registers, with ci = borrow register.
  - At the edge:
    - the sub4 difference nibble shifts into the top of the result shift register;
    - the operand registers shift right by 4;
    - the borrow register takes sub4 co;
    - the counter increments.
  - After the edge that processes nibble NIBBLES-1, go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - diff = result register; bout = final borrow; ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]). The operand MSBs for ovf are captured at start.
  - diff, bout and ovf are registered. They update on the edge entering DONE and hold until the next entry to DONE.
- Latency:
  - start sampled at edge k gives done=1 during the cycle after edge k+NIBBLES.
  - That is NIBBLES+1 cycles from the start edge to the done cycle. Throughput is one operation per NIBBLES+1 cycles.
- start while busy (RUN): ignored, with no effect on the operation in flight.
- start during DONE: accepted, latching new operands and going directly to RUN. This gives back-to-back operation with no idle cycle.
- DONE with start=0: go to IDLE.
- Arithmetic is modulo 2^W. The borrow is the only carry between nibbles, and the wrap of 0 - 1 gives all-ones with bout=1.
- Reset mid-RUN: aborts immediately. Outputs return to reset values, and no done pulse is produced for the aborted operation.
- Inputs a, b and bin are don't-care outside the accepted start cycle.

Decomposition:
- Shared include/package:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - NIBBLE_W=4.
- Counter width is derived from NIBBLES (clog2, minimum 1).
- One sub-module: the existing sub4 (built on full_sub), instantiated once as the datapath slice.
- FSM, shift registers and borrow register live in sub_serial_seq.

Test Plan:
- a=16'h1234, b=16'h0234, bin=0, start pulse → done exactly 5 cycles after the start edge; diff=16'h1000, bout=0, ovf=0; busy high for 4 cycles.
- a=16'h0000, b=16'h0001, bin=0 → diff=16'hFFFF, bout=1, ovf=0. Then a=16'h0000, b=16'h0000, bin=1 → diff=16'hFFFF, bout=1.
- a=16'h8000, b=16'h0001 → diff=16'h7FFF, ovf=1, bout=0. Then a=16'h7FFF, b=16'hFFFF → diff=16'h8000, ovf=1, bout=1.
- Start a=16'h00F0, b=16'h000F, then pulse start with a=16'hFFFF during cycle 2 of RUN → second start ignored; diff=16'h00E1, a single done pulse.
- Hold start=1 through DONE with new operands a=16'h0010, b=16'h0001 → second op starts with no IDLE cycle. done pulses at start+5 and start+10; second diff=16'h000F; diff holds 16'h00E1-style prior result until the second done.
- Deassert rst_n asynchronously mid-RUN (between edges) → busy, done, diff, bout and ovf go to 0 immediately. After release, IDLE with no done pulse; a fresh start then completes normally.
